// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared types and constants for the UART transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] c_par_none = 2'b00;
    localparam logic [1:0] c_par_even = 2'b01;
    localparam logic [1:0] c_par_odd  = 2'b10;

    localparam int c_min_div = 2;

    // Mode 2'b11 is deliberately treated the same as no parity.
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == c_par_even) || (mode == c_par_odd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_ctrl_if : valid/ready byte input channel of the UART transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo : transmit buffer (storage, pointers, level); used with UART_TX_FIFO_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (r_level == (AW+1)'(DEPTH));
    assign empty = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_ctrl : UART transmitter, start/data/parity/stop framing. Define
// UART_TX_FIFO_EN for a FIFO_DEPTH buffer, else a single holding register.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    cfg_par,
    input  logic                          cfg_stop2,
    uart_tx_ctrl_if.slave                 in_if,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] c_last_bit = 4'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_bit_end;
    logic [DIV_W-1:0]  w_div_eff;

    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic [3:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;

    assign w_push          = in_if.in_valid && in_if.in_ready;
    assign in_if.in_ready  = !rst && !w_full;

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (w_push),
        .pop    (w_pop),
        .wdata  (in_if.in_data),
        .rdata  (w_head),
        .level  (level),
        .full   (w_full),
        .empty  (w_empty)
    );
`else
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_hold_data;

    // Push and pop never coincide here: in_ready is low whenever the register holds data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_push) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= in_if.in_data;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign w_head  = r_hold_data;
    assign w_full  = r_hold_valid;
    assign w_empty = !r_hold_valid;
    assign level   = {{(LVL_W-1){1'b0}}, r_hold_valid};
`endif

    assign w_bit_end = (r_cnt == r_div - 1'b1);
    assign w_div_eff = (baud_div < DIV_W'(c_min_div)) ? DIV_W'(c_min_div) : baud_div;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = ST_START;
                end
            end
            ST_START:  if (w_bit_end) w_state_nx = ST_DATA;
            ST_DATA: begin
                if (w_bit_end && r_bit == c_last_bit)
                    w_state_nx = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_bit_end) w_state_nx = ST_STOP;
            ST_STOP: begin
                // The next frame, if queued, starts without an idle gap.
                if (w_bit_end && (!r_stop2 || r_bit == 4'd1)) begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_state_nx = ST_START;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (r_state != ST_IDLE);
        case (r_state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = r_shift[0];
            ST_PARITY: tx = r_par_bit;
            default:   tx = 1'b1;
        endcase
    end

    // Frame settings are captured at the pop so mid-frame changes only affect later frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= DIV_W'(c_min_div);
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_div     <= w_div_eff;
                r_par_en  <= par_enabled(cfg_par);
                r_par_bit <= (^w_head) ^ (cfg_par == c_par_odd);
                r_stop2   <= cfg_stop2;
                r_shift   <= w_head;
            end
            if (w_state_nx != r_state) begin
                r_cnt <= '0;
                r_bit <= '0;
            end else if (r_state != ST_IDLE) begin
                if (w_bit_end) begin
                    r_cnt <= '0;
                    r_bit <= r_bit + 1'b1;
                    if (r_state == ST_DATA) r_shift <= r_shift >> 1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
